// File: rtl/button_pkg.sv
// Shared FSM state type, default timing constants and counter sizing helper
// for the push-button bank.
package button_pkg;

   typedef enum logic [1:0] {
      RELEASED = 2'd0,
      PRESSED  = 2'd1,
      HELD     = 2'd2
   } btn_state_t;

   // Defaults assume a 100 MHz clock: 10 ms debounce, 500 ms long press, 100 ms repeat.
   localparam int DEFAULT_DEBOUNCE_LIMIT = 1_000_000;
   localparam int DEFAULT_LONG_LIMIT     = 50_000_000;
   localparam int DEFAULT_REPEAT_PERIOD  = 10_000_000;

   // Width of a counter that runs 0..limit-1; never narrower than one bit.
   function automatic int cnt_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/button_chan.sv
// One push-button channel: two-flop synchronizer, debounce filter and the
// RELEASED/PRESSED/HELD FSM. Auto-repeat exists only with BUTTON_BANK_REPEAT_EN.
module button_chan
   import button_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
   parameter int LONG_LIMIT     = DEFAULT_LONG_LIMIT,
   parameter int REPEAT_PERIOD  = DEFAULT_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic reset,
   input  logic pbi,
   output logic level,
   output logic press,
   output logic rel,
   output logic long,
   output logic rpt
);
   localparam int DB_W   = cnt_width(DEBOUNCE_LIMIT);
   localparam int LONG_W = cnt_width(LONG_LIMIT);
`ifdef BUTTON_BANK_REPEAT_EN
   localparam int RPT_W  = cnt_width(REPEAT_PERIOD);
   localparam int HOLD_W = (LONG_W > RPT_W) ? LONG_W : RPT_W;
   localparam logic [HOLD_W-1:0] RPT_LAST = HOLD_W'(REPEAT_PERIOD - 1);
`else
   localparam int HOLD_W = LONG_W;
`endif
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_LIMIT - 1);

   if (DEBOUNCE_LIMIT < 1 || LONG_LIMIT < 1 || REPEAT_PERIOD < 1) begin : g_bad_limits
      $error("button_chan: DEBOUNCE_LIMIT, LONG_LIMIT and REPEAT_PERIOD must be at least 1");
   end

   logic              r_sync1, r_sync2, r_level, r_press, r_rel, r_long;
   logic [DB_W-1:0]   r_db_cnt;
   logic [HOLD_W-1:0] r_hold_cnt;
   btn_state_t        r_state;

   logic              w_mismatch, w_toggle, w_rise, w_fall, w_long_next;
   logic [HOLD_W-1:0] w_hold_next;
   btn_state_t        w_state_next;
`ifdef BUTTON_BANK_REPEAT_EN
   logic              r_rpt, w_rpt_next;
`endif

   assign w_mismatch = r_sync2 ^ r_level;
   assign w_toggle   = w_mismatch && (r_db_cnt == DB_LAST);
   assign w_rise     = w_toggle & ~r_level;
   assign w_fall     = w_toggle & r_level;

   // A debounced fall always takes priority over the long/repeat thresholds.
   always_comb begin
      w_state_next = r_state;
      w_hold_next  = r_hold_cnt;
      w_long_next  = 1'b0;
`ifdef BUTTON_BANK_REPEAT_EN
      w_rpt_next   = 1'b0;
`endif
      case (r_state)
         RELEASED: begin
            w_hold_next = '0;
            if (w_rise) w_state_next = PRESSED;
         end
         PRESSED: begin
            if (w_fall) begin
               w_state_next = RELEASED;
               w_hold_next  = '0;
            end else if (r_hold_cnt == LONG_LAST) begin
               w_state_next = HELD;
               w_hold_next  = '0;
               w_long_next  = 1'b1;
            end else begin
               w_hold_next = r_hold_cnt + 1'b1;
            end
         end
         HELD: begin
            if (w_fall) begin
               w_state_next = RELEASED;
               w_hold_next  = '0;
            end
`ifdef BUTTON_BANK_REPEAT_EN
            else if (r_hold_cnt == RPT_LAST) begin
               w_hold_next = '0;
               w_rpt_next  = 1'b1;
            end else begin
               w_hold_next = r_hold_cnt + 1'b1;
            end
`endif
         end
         default: begin
            w_state_next = RELEASED;
            w_hold_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_level    <= 1'b0;
         r_db_cnt   <= '0;
         r_press    <= 1'b0;
         r_rel      <= 1'b0;
         r_long     <= 1'b0;
         r_hold_cnt <= '0;
         r_state    <= RELEASED;
      end else begin
         r_sync1    <= pbi;
         r_sync2    <= r_sync1;
         r_db_cnt   <= (!w_mismatch || w_toggle) ? '0 : r_db_cnt + 1'b1;
         if (w_toggle) r_level <= ~r_level;
         r_press    <= w_rise;
         r_rel      <= w_fall;
         r_long     <= w_long_next;
         r_hold_cnt <= w_hold_next;
         r_state    <= w_state_next;
      end
   end

`ifdef BUTTON_BANK_REPEAT_EN
   always_ff @(posedge clk) begin
      if (reset) r_rpt <= 1'b0;
      else       r_rpt <= w_rpt_next;
   end
   assign rpt = r_rpt;
`else
   assign rpt = 1'b0;
`endif

   assign level = r_level;
   assign press = r_press;
   assign rel   = r_rel;
   assign long  = r_long;

endmodule

// File: rtl/button_bank.sv
// Bank of N independent debounced push buttons with press/release/long/repeat pulses.
// Define BUTTON_BANK_REPEAT_EN for auto-repeat on rpt; release pulses appear on rel.
module button_bank
   import button_pkg::*;
#(
   parameter int N              = 5,
   parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
   parameter int LONG_LIMIT     = DEFAULT_LONG_LIMIT,
   parameter int REPEAT_PERIOD  = DEFAULT_REPEAT_PERIOD
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] pbi,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   output logic [N-1:0] rel,
   output logic [N-1:0] long,
   output logic [N-1:0] rpt
);
   if (N < 1 || N > 32) begin : g_bad_n
      $error("button_bank: N must be in 1..32");
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_chan
      button_chan #(
         .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
         .LONG_LIMIT     (LONG_LIMIT),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_chan (
         .clk   (clk),
         .reset (reset),
         .pbi   (pbi[gi]),
         .level (level[gi]),
         .press (press[gi]),
         .rel   (rel[gi]),
         .long  (long[gi]),
         .rpt   (rpt[gi])
      );
   end

endmodule

// File: tb/tb_button_bank.sv
// Randomized and directed bench for button_bank against an event/timestamp model.
module tb_button_bank;
   localparam int N  = 2;
   localparam int DB = 4;
   localparam int LL = 20;
   localparam int RP = 5;
`ifdef BUTTON_BANK_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] pbi, level, press, rel, lng, rpt;

   int checks = 0;
   int errors = 0;
   int t = 0;

   // Reference model state: debounced level, mismatch run length and event timestamps.
   logic [N-1:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_long, m_rpt;
   int m_run[N], m_press_t[N], m_long_t[N];

   button_bank #(.N(N), .DEBOUNCE_LIMIT(DB), .LONG_LIMIT(LL), .REPEAT_PERIOD(RP)) dut (
      .clk(clk), .reset(reset), .pbi(pbi), .level(level),
      .press(press), .rel(rel), .long(lng), .rpt(rpt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout at edge %0d", t);
      $fatal(1, "watchdog");
   end

   function automatic void model_edge(input logic [N-1:0] p, input logic r);
      if (r) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0;
         m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0;
         for (int c = 0; c < N; c++) begin
            m_run[c] = 0; m_press_t[c] = -1; m_long_t[c] = -1;
         end
      end else begin
         for (int c = 0; c < N; c++) begin
            logic lvl_old;
            lvl_old = m_lvl[c];
            m_press[c] = 1'b0; m_rel[c] = 1'b0; m_long[c] = 1'b0; m_rpt[c] = 1'b0;
            if (m_s2[c] != lvl_old) begin
               m_run[c]++;
               if (m_run[c] == DB) begin
                  m_lvl[c] = ~lvl_old;
                  m_run[c] = 0;
               end
            end else begin
               m_run[c] = 0;
            end
            if (m_lvl[c] && !lvl_old) begin
               m_press[c] = 1'b1; m_press_t[c] = t; m_long_t[c] = -1;
            end
            if (!m_lvl[c] && lvl_old) begin
               m_rel[c] = 1'b1; m_press_t[c] = -1; m_long_t[c] = -1;
            end
            if (m_lvl[c] && m_press_t[c] >= 0 && (t - m_press_t[c]) == LL) begin
               m_long[c] = 1'b1; m_long_t[c] = t;
            end
            if (REP_EN && m_lvl[c] && m_long_t[c] >= 0 && t > m_long_t[c] &&
                ((t - m_long_t[c]) % RP) == 0)
               m_rpt[c] = 1'b1;
         end
         m_s2 = m_s1;
         m_s1 = p;
      end
   endfunction

   function automatic logic [5*N-1:0] obs();
      return {level, press, rel, lng, rpt};
   endfunction

   function automatic logic [5*N-1:0] expv();
      return {m_lvl, m_press, m_rel, m_long, m_rpt};
   endfunction

   task automatic step(input logic [N-1:0] p, input logic r);
      pbi   = p;
      reset = r;
      @(posedge clk);
      t++;
      model_edge(p, r);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(N'($urandom), 1'b1);
         checks++;
         if (obs() !== '0) begin
            errors++; $display("FAIL reset_outputs cycle=%0d got=%b exp=0", i, obs());
         end
      end
      $display("test_reset: 3 reset cycles");
   endtask

   task automatic test_clean_press();
      int first, cnt, ch1_bad;
      first = -1; cnt = 0; ch1_bad = 0;
      for (int i = 0; i < 8; i++) begin
         step('0, 1'b0);
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL clean_idle t=%0d got=%b exp=%b", t, obs(), expv()); end
      end
      for (int i = 1; i <= 12; i++) begin
         step(2'b01, 1'b0);
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL clean_model t=%0d got=%b exp=%b", t, obs(), expv()); end
         if (press[0]) begin cnt++; if (first < 0) first = i; end
         if (level[1] | press[1] | rel[1] | lng[1] | rpt[1]) ch1_bad++;
      end
      checks++;
      if (first !== 6) begin errors++; $display("FAIL clean_press_latency got=%0d exp=6", first); end
      checks++;
      if (cnt !== 1) begin errors++; $display("FAIL clean_press_count got=%0d exp=1", cnt); end
      checks++;
      if (ch1_bad !== 0) begin errors++; $display("FAIL clean_ch1_quiet got=%0d exp=0", ch1_bad); end
      checks++;
      if (level[0] !== 1'b1) begin errors++; $display("FAIL clean_level got=%b exp=1", level[0]); end
      $display("test_clean_press: press[0] after %0d cycles", first);
   endtask

   task automatic test_bounce();
      int bad;
      logic [N-1:0] p;
      bad = 0;
      for (int i = 0; i < 27; i++) begin
         p = '0;
         p[1] = (i < 12) ? ((i / 3) % 2 == 0) : 1'b0;
         step(p, 1'b0);
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL bounce_model t=%0d got=%b exp=%b", t, obs(), expv()); end
         if (level[1] | press[1] | rel[1]) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL bounce_ch1 got=%0d events exp=0", bad); end
      $display("test_bounce: %0d channel-1 events", bad);
   endtask

   task automatic test_long_hold();
      int long_cnt, long_off, rpt_cnt, rpt_first, rpt_last, rel_cnt, late_long;
      int exp_rpt_cnt, exp_rpt_first, exp_rpt_last;
      bit got;
      long_cnt = 0; long_off = -1; rpt_cnt = 0; rpt_first = -1; rpt_last = -1;
      rel_cnt = 0; late_long = 0; got = 0;
      exp_rpt_cnt   = REP_EN ? 3 : 0;
      exp_rpt_first = REP_EN ? LL + RP : -1;
      exp_rpt_last  = REP_EN ? LL + 3 * RP : -1;
      for (int i = 0; i < 12; i++) begin
         step('0, 1'b0);
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL long_idle t=%0d got=%b exp=%b", t, obs(), expv()); end
      end
      for (int i = 0; i < 12 && !got; i++) begin
         step(2'b01, 1'b0);
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL long_press_model t=%0d got=%b exp=%b", t, obs(), expv()); end
         if (press[0]) got = 1;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL long_press_timeout got=none exp=press[0]"); end
      for (int k = 1; k <= 40; k++) begin
         step(2'b01, 1'b0);
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL long_hold_model t=%0d got=%b exp=%b", t, obs(), expv()); end
         if (lng[0]) begin long_cnt++; long_off = k; end
         if (rpt[0] && k <= 38) begin
            rpt_cnt++; if (rpt_first < 0) rpt_first = k; rpt_last = k;
         end
      end
      for (int i = 0; i < 12; i++) begin
         step('0, 1'b0);
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL long_drop_model t=%0d got=%b exp=%b", t, obs(), expv()); end
         if (rel[0]) rel_cnt++;
         if (lng[0]) late_long++;
      end
      checks++;
      if (long_cnt !== 1) begin errors++; $display("FAIL long_count got=%0d exp=1", long_cnt); end
      checks++;
      if (long_off !== LL) begin errors++; $display("FAIL long_offset got=%0d exp=%0d", long_off, LL); end
      checks++;
      if (rpt_cnt !== exp_rpt_cnt) begin errors++; $display("FAIL rpt_count got=%0d exp=%0d", rpt_cnt, exp_rpt_cnt); end
      checks++;
      if (rpt_first !== exp_rpt_first) begin errors++; $display("FAIL rpt_first got=%0d exp=%0d", rpt_first, exp_rpt_first); end
      checks++;
      if (rpt_last !== exp_rpt_last) begin errors++; $display("FAIL rpt_last got=%0d exp=%0d", rpt_last, exp_rpt_last); end
      checks++;
      if (rel_cnt !== 1) begin errors++; $display("FAIL long_release_count got=%0d exp=1", rel_cnt); end
      checks++;
      if (late_long !== 0) begin errors++; $display("FAIL long_after_drop got=%0d exp=0", late_long); end
      $display("test_long_hold: long at +%0d, %0d repeats", long_off, rpt_cnt);
   endtask

   task automatic test_release_at_threshold();
      int rel_off, long_cnt;
      bit got;
      rel_off = -1; long_cnt = 0; got = 0;
      for (int i = 0; i < 12; i++) step('0, 1'b0);
      for (int i = 0; i < 12 && !got; i++) begin
         step(2'b01, 1'b0);
         if (press[0]) got = 1;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL thresh_press_timeout got=none exp=press[0]"); end
      for (int k = 1; k <= 26; k++) begin
         step((k <= 14) ? 2'b01 : 2'b00, 1'b0);
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL thresh_model t=%0d got=%b exp=%b", t, obs(), expv()); end
         if (rel[0] && rel_off < 0) rel_off = k;
         if (lng[0]) long_cnt++;
      end
      checks++;
      if (rel_off !== LL) begin errors++; $display("FAIL thresh_release_offset got=%0d exp=%0d", rel_off, LL); end
      checks++;
      if (long_cnt !== 0) begin errors++; $display("FAIL thresh_long_suppressed got=%0d exp=0", long_cnt); end
      $display("test_release_at_threshold: release at +%0d, long pulses %0d", rel_off, long_cnt);
   endtask

   task automatic test_simultaneous();
      logic [N-1:0] first;
      int off;
      first = '0; off = -1;
      for (int i = 0; i < 12; i++) step('0, 1'b0);
      for (int k = 1; k <= 12 && off < 0; k++) begin
         step(2'b11, 1'b0);
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL simul_model t=%0d got=%b exp=%b", t, obs(), expv()); end
         if (press !== '0) begin first = press; off = k; end
      end
      checks++;
      if (first !== 2'b11) begin errors++; $display("FAIL simul_press got=%b exp=11", first); end
      checks++;
      if (off !== 2 + DB) begin errors++; $display("FAIL simul_latency got=%0d exp=%0d", off, 2 + DB); end
      $display("test_simultaneous: press=%b at +%0d", first, off);
   endtask

   task automatic test_reset_mid_hold();
      bit got;
      int rel_cnt, press_off;
      got = 0; rel_cnt = 0; press_off = -1;
      for (int i = 0; i < 30 && !got; i++) begin
         step(2'b11, 1'b0);
         if (lng[0]) got = 1;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL midreset_long_timeout got=none exp=long[0]"); end
      step(2'b11, 1'b0);
      step(2'b11, 1'b0);
      step(2'b11, 1'b1);
      checks++;
      if (obs() !== '0) begin errors++; $display("FAIL midreset_outputs got=%b exp=0", obs()); end
      for (int k = 1; k <= 10; k++) begin
         step(2'b11, 1'b0);
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL midreset_model t=%0d got=%b exp=%b", t, obs(), expv()); end
         if (rel !== '0) rel_cnt++;
         if (press[0] && press_off < 0) press_off = k;
      end
      checks++;
      if (rel_cnt !== 0) begin errors++; $display("FAIL midreset_release got=%0d exp=0", rel_cnt); end
      checks++;
      if (press_off !== 2 + DB) begin errors++; $display("FAIL midreset_repress got=%0d exp=%0d", press_off, 2 + DB); end
      $display("test_reset_mid_hold: press[0] back at +%0d", press_off);
   endtask

   task automatic test_random();
      logic [N-1:0] cur;
      int hold_left[N];
      int resets;
      logic do_rst;
      cur = '0; resets = 0;
      for (int c = 0; c < N; c++) hold_left[c] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int c = 0; c < N; c++) begin
            if (hold_left[c] == 0) begin
               cur[c] = ~cur[c];
               hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70))
                                                          : int'($urandom_range(1, 6));
            end
            hold_left[c]--;
         end
         do_rst = ($urandom_range(0, 499) == 0);
         if (do_rst) resets++;
         step(cur, do_rst);
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL random_model t=%0d got=%b exp=%b", t, obs(), expv()); end
      end
      $display("test_random: 3000 cycles, %0d resets", resets);
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_hold();
      test_release_at_threshold();
      test_simultaneous();
      test_reset_mid_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
